tl_burst_arbiter: RTL and testbench

- N-requester arbiter sharing one directory/L2 request port between the L1 masters' TileLink Channel A and Channel C streams.
- Channel C has priority over Channel A. Within each channel, masters are served round-robin.
- Multi-beat data messages are locked: once the first beat is accepted, the grant stays with that master and channel until the last beat transfers.
- Sits between the L1 master ports and the directory controller input stage.

---
 rtl/tidc_tl_pkg.sv | 49 ++++
 rtl/tl_rr_pick.sv | 46 ++++
 rtl/tl_burst_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_tl_burst_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tidc_tl_pkg.sv
//==============================================================================
// Module      : tidc_tl_pkg
// Description : TileLink definitions shared by the L1-to-directory request
//               path. Contains the channel encodings, the data-carrying
//               opcodes, the arbiter state type and the beat-count helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tidc_tl_pkg;

    // Channel encodings as they appear on out_channel
    localparam logic CH_A = 1'b0;
    localparam logic CH_C = 1'b1;

    // Data-carrying opcodes. Only these can span multiple beats.
    localparam logic [2:0] A_PUTFULL      = 3'd0;
    localparam logic [2:0] A_PUTPARTIAL   = 3'd1;
    localparam logic [2:0] C_PROBEACKDATA = 3'd5;
    localparam logic [2:0] C_RELEASEDATA  = 3'd7;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Number of beats a message occupies. Non-data messages and data
    // messages no larger than one beat take a single beat.
    function automatic logic [31:0] beat_count(
        input logic [2:0]  opcode,
        input logic        channel,
        input int unsigned size,
        input int unsigned beat_bytes_log2
    );
        logic is_data;
        if (channel == CH_A) begin
            is_data = (opcode == A_PUTFULL) || (opcode == A_PUTPARTIAL);
        end else begin
            is_data = (opcode == C_PROBEACKDATA) || (opcode == C_RELEASEDATA);
        end
        if (!is_data || (size <= beat_bytes_log2)) begin
            return 32'd1;
        end
        return 32'd1 << (size - beat_bytes_log2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_rr_pick.sv
//==============================================================================
// Module      : tl_rr_pick
// Description : N-way round-robin selector. Picks the first asserted request
//               searching upward from i_ptr+1 (modulo N).
// Ports       : i_req   - request vector
//               i_ptr   - index of the most recently served requester
//               o_grant - one-hot grant (all zero when nothing requests)
//               o_idx   - binary index of the granted requester
//               o_any   - at least one request is asserted
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tl_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Offsets 1..N cover every requester once, ending on i_ptr itself so a
    // lone requester is always found regardless of the pointer.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

    assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/tl_burst_arbiter.sv
//==============================================================================
// Module      : tl_burst_arbiter
// Description : Shares one directory/L2 request port between the Channel A
//               and Channel C streams of NUM_MASTERS L1 masters. C has
//               priority over A, masters within a channel are served
//               round-robin, and multi-beat data messages hold the grant
//               until their last beat transfers.
// Ports       : a_* / c_*   - per-master packed Channel A / Channel C inputs
//                             and per-master ready outputs
//               out_*       - granted beat towards the directory input stage
//               busy        - a multi-beat message is in progress
// Options     : TL_ARB_ANTISTARVE_EN - after STARVE_LIMIT consecutive C
//               messages completed while A is pending, the next idle
//               decision goes to A.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tl_burst_arbiter
    import tidc_tl_pkg::*;
#(
    parameter int NUM_MASTERS  = 2,
    parameter int PAYLOAD_W    = 96,
    parameter int BEAT_BYTES   = 8,
    parameter int SIZE_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            a_valid_i,
    output logic [NUM_MASTERS-1:0]            a_ready_o,
    input  logic [3*NUM_MASTERS-1:0]          a_opcode_i,
    input  logic [SIZE_W*NUM_MASTERS-1:0]     a_size_i,
    input  logic [PAYLOAD_W*NUM_MASTERS-1:0]  a_payload_i,
    input  logic [NUM_MASTERS-1:0]            c_valid_i,
    output logic [NUM_MASTERS-1:0]            c_ready_o,
    input  logic [3*NUM_MASTERS-1:0]          c_opcode_i,
    input  logic [SIZE_W*NUM_MASTERS-1:0]     c_size_i,
    input  logic [PAYLOAD_W*NUM_MASTERS-1:0]  c_payload_i,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_channel,
    output logic [$clog2(NUM_MASTERS)-1:0]    out_master_id,
    output logic [2:0]                        out_opcode,
    output logic [SIZE_W-1:0]                 out_size,
    output logic [PAYLOAD_W-1:0]              out_payload,
    output logic                              out_first,
    output logic                              out_last,
    output logic                              busy
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int BB_LOG = $clog2(BEAT_BYTES);
    // Largest message is 2^(2^SIZE_W-1) bytes; the counter holds that
    // many beats.
    localparam int CNT_W  = (1 << SIZE_W) - BB_LOG;
    localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_e             r_state;
    logic                   r_lock_ch;
    logic [IDX_W-1:0]       r_lock_mst;
    logic [CNT_W-1:0]       r_remaining;
    logic [IDX_W-1:0]       r_ptr_a;
    logic [IDX_W-1:0]       r_ptr_c;

    logic [2:0]             w_a_op  [NUM_MASTERS];
    logic [2:0]             w_c_op  [NUM_MASTERS];
    logic [SIZE_W-1:0]      w_a_sz  [NUM_MASTERS];
    logic [SIZE_W-1:0]      w_c_sz  [NUM_MASTERS];
    logic [PAYLOAD_W-1:0]   w_a_pl  [NUM_MASTERS];
    logic [PAYLOAD_W-1:0]   w_c_pl  [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] w_a_onehot;
    logic [NUM_MASTERS-1:0] w_c_onehot;
    logic [IDX_W-1:0]       w_a_idx;
    logic [IDX_W-1:0]       w_c_idx;
    logic                   w_a_any;
    logic                   w_c_any;

    logic                   w_ch;
    logic [IDX_W-1:0]       w_mst;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic                   w_valid;
    logic [CNT_W-1:0]       w_beats;
    logic                   w_accept;
    logic [STV_W-1:0]       w_starve_cnt;
    logic                   w_force_a;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign w_a_op[g] = a_opcode_i[g*3 +: 3];
        assign w_c_op[g] = c_opcode_i[g*3 +: 3];
        assign w_a_sz[g] = a_size_i[g*SIZE_W +: SIZE_W];
        assign w_c_sz[g] = c_size_i[g*SIZE_W +: SIZE_W];
        assign w_a_pl[g] = a_payload_i[g*PAYLOAD_W +: PAYLOAD_W];
        assign w_c_pl[g] = c_payload_i[g*PAYLOAD_W +: PAYLOAD_W];
    end

    tl_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_a (
        .i_req   (a_valid_i),
        .i_ptr   (r_ptr_a),
        .o_grant (w_a_onehot),
        .o_idx   (w_a_idx),
        .o_any   (w_a_any)
    );

    tl_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_c (
        .i_req   (c_valid_i),
        .i_ptr   (r_ptr_c),
        .o_grant (w_c_onehot),
        .o_idx   (w_c_idx),
        .o_any   (w_c_any)
    );

    // Grant selection: the lock wins outright; otherwise C beats A unless
    // the anti-starvation counter has tripped.
    always_comb begin
        w_ch     = CH_A;
        w_mst    = '0;
        w_onehot = '0;
        w_valid  = 1'b0;
        if (r_state == ARB_LOCKED) begin
            w_ch     = r_lock_ch;
            w_mst    = r_lock_mst;
            w_onehot = NUM_MASTERS'(1) << r_lock_mst;
            w_valid  = (r_lock_ch == CH_C) ? c_valid_i[r_lock_mst] : a_valid_i[r_lock_mst];
        end else if (w_c_any && !w_force_a) begin
            w_ch     = CH_C;
            w_mst    = w_c_idx;
            w_onehot = w_c_onehot;
            w_valid  = 1'b1;
        end else begin
            w_ch     = CH_A;
            w_mst    = w_a_idx;
            w_onehot = w_a_onehot;
            w_valid  = w_a_any;
        end
    end

    assign out_channel   = w_ch;
    assign out_master_id = w_mst;
    assign out_opcode    = (w_ch == CH_C) ? w_c_op[w_mst] : w_a_op[w_mst];
    assign out_size      = (w_ch == CH_C) ? w_c_sz[w_mst] : w_a_sz[w_mst];
    assign out_payload   = (w_ch == CH_C) ? w_c_pl[w_mst] : w_a_pl[w_mst];

    // Only meaningful in IDLE, where the current beat is a first beat.
    assign w_beats   = CNT_W'(beat_count(out_opcode, w_ch, 32'(out_size), 32'(BB_LOG)));

    assign out_first = (r_state == ARB_IDLE);
    assign out_last  = (r_state == ARB_IDLE) ? (w_beats == CNT_W'(1))
                                             : (r_remaining == CNT_W'(1));
    assign busy      = (r_state == ARB_LOCKED);

    // rst_n gates the handshake directly so nothing transfers while held.
    assign out_valid = rst_n & w_valid;
    assign w_accept  = out_valid & out_ready;
    assign a_ready_o = (rst_n && out_ready && (w_ch == CH_A)) ? w_onehot : '0;
    assign c_ready_o = (rst_n && out_ready && (w_ch == CH_C)) ? w_onehot : '0;

`ifdef TL_ARB_ANTISTARVE_EN
    logic [STV_W-1:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_a_any) begin
            r_starve_cnt <= '0;
        end else if (w_accept && out_last) begin
            if (w_ch == CH_A) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STV_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
            end
        end
    end

    assign w_starve_cnt = r_starve_cnt;
`else
    assign w_starve_cnt = '0;
`endif

    assign w_force_a = w_a_any && (w_starve_cnt >= STV_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_lock_ch   <= CH_A;
            r_lock_mst  <= '0;
            r_remaining <= '0;
            r_ptr_a     <= IDX_W'(NUM_MASTERS - 1);
            r_ptr_c     <= IDX_W'(NUM_MASTERS - 1);
        end else if (w_accept) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_beats != CNT_W'(1)) begin
                        r_state     <= ARB_LOCKED;
                        r_lock_ch   <= w_ch;
                        r_lock_mst  <= w_mst;
                        r_remaining <= w_beats - CNT_W'(1);
                    end
                end
                ARB_LOCKED: begin
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= ARB_IDLE;
                    end
                end
            endcase
            // Pointer advances only once the whole message has gone.
            if (out_last) begin
                if (w_ch == CH_C) begin
                    r_ptr_c <= w_mst;
                end else begin
                    r_ptr_a <= w_mst;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tl_burst_arbiter.sv
//==============================================================================
// Module      : tb_tl_burst_arbiter
// Description : Self-checking bench for tl_burst_arbiter. Masters are driven
//               from per-master message slots; a message-level reference
//               model predicts every cycle's grant, ready vector and flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tl_burst_arbiter;

    localparam int N  = 2;
    localparam int PW = 96;
    localparam int BB = 8;
    localparam int SW = 4;
    localparam int SL = 4;
`ifdef TL_ARB_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       a_valid_i, a_ready_o, c_valid_i, c_ready_o;
    logic [3*N-1:0]     a_opcode_i, c_opcode_i;
    logic [SW*N-1:0]    a_size_i, c_size_i;
    logic [PW*N-1:0]    a_payload_i, c_payload_i;
    logic               out_valid, out_ready, out_channel, out_first, out_last, busy;
    logic [$clog2(N)-1:0] out_master_id;
    logic [2:0]         out_opcode;
    logic [SW-1:0]      out_size;
    logic [PW-1:0]      out_payload;

    always #5 clk = ~clk;

    tl_burst_arbiter #(
        .NUM_MASTERS(N), .PAYLOAD_W(PW), .BEAT_BYTES(BB), .SIZE_W(SW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
        .a_size_i(a_size_i), .a_payload_i(a_payload_i),
        .c_valid_i(c_valid_i), .c_ready_o(c_ready_o), .c_opcode_i(c_opcode_i),
        .c_size_i(c_size_i), .c_payload_i(c_payload_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .out_master_id(out_master_id), .out_opcode(out_opcode), .out_size(out_size),
        .out_payload(out_payload), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    // Master-side message slots, indexed [channel][master]
    bit          d_has  [2][N];
    bit          d_drop [2][N];
    int          d_op   [2][N];
    int          d_sz   [2][N];
    logic [PW-1:0] d_pay [2][N];
    int          mode;          // 0 random, 1 starvation traffic, 2 directed

    // Reference model state
    int m_ptr [2];
    bit m_lock;
    int m_lch, m_lm, m_total, m_done, m_starve;
    bit e_valid, e_first, e_last;
    int e_ch, e_m, e_beats;

    // DUT observations for the starvation scenario
    int obs_c_done, obs_a_at;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_beats(input int ch, input int op, input int sz);
        bit data;
        int per;
        data = (ch == 1) ? (op == 5 || op == 7) : (op == 0 || op == 1);
        per  = (1 << sz) / BB;
        if (!data || per < 1) return 1;
        return per;
    endfunction

    task automatic pack();
        for (int m = 0; m < N; m++) begin
            a_valid_i[m]             = d_has[0][m] && !d_drop[0][m];
            c_valid_i[m]             = d_has[1][m] && !d_drop[1][m];
            a_opcode_i[m*3 +: 3]     = 3'(d_op[0][m]);
            c_opcode_i[m*3 +: 3]     = 3'(d_op[1][m]);
            a_size_i[m*SW +: SW]     = SW'(d_sz[0][m]);
            c_size_i[m*SW +: SW]     = SW'(d_sz[1][m]);
            a_payload_i[m*PW +: PW]  = d_pay[0][m];
            c_payload_i[m*PW +: PW]  = d_pay[1][m];
        end
    endtask

    task automatic clear_masters();
        for (int ch = 0; ch < 2; ch++) begin
            for (int m = 0; m < N; m++) begin
                d_has[ch][m] = 1'b0; d_drop[ch][m] = 1'b0;
                d_op[ch][m] = 0; d_sz[ch][m] = 0; d_pay[ch][m] = '0;
            end
        end
        pack();
    endtask

    task automatic set_msg(input int ch, input int m, input int op, input int sz);
        d_has[ch][m] = 1'b1; d_op[ch][m] = op; d_sz[ch][m] = sz; d_drop[ch][m] = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr[0] = N - 1; m_ptr[1] = N - 1;
        m_lock = 1'b0; m_lch = 0; m_lm = 0; m_total = 0; m_done = 0; m_starve = 0;
        obs_c_done = 0; obs_a_at = -1;
    endtask

    task automatic new_stimulus();
        for (int ch = 0; ch < 2; ch++) begin
            for (int m = 0; m < N; m++) begin
                if (!d_has[ch][m]) begin
                    if (mode == 0 && ($urandom % 2) == 0) begin
                        if (ch == 0) begin
                            case ($urandom % 3)
                                0: set_msg(0, m, 0, int'($urandom % 7));
                                1: set_msg(0, m, 1, int'($urandom % 7));
                                default: set_msg(0, m, 4, int'($urandom % 7));
                            endcase
                        end else begin
                            set_msg(1, m, 4 + int'($urandom % 4), int'($urandom % 7));
                        end
                    end else if (mode == 1 && ch == 1) begin
                        set_msg(1, m, 6, 3);
                    end else if (mode == 1 && m == 0) begin
                        set_msg(0, m, 4, 6);
                    end
                end
                d_drop[ch][m] = (mode == 0) && (($urandom % 8) == 0);
                d_pay[ch][m]  = {$urandom, $urandom, $urandom};
            end
        end
        if (mode == 0) out_ready = ($urandom % 100) < 70;
        if (mode == 1) out_ready = 1'b1;
        pack();
    endtask

    // Expected grant from the priority/round-robin rules
    task automatic model_eval();
        bit force_a;
        e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_beats = 1; e_m = 0;
        if (m_lock) begin
            e_ch    = m_lch;
            e_m     = m_lm;
            e_valid = (e_ch == 1) ? c_valid_i[e_m] : a_valid_i[e_m];
            e_last  = (m_done + 1 == m_total);
            e_beats = m_total;
        end else begin
            force_a = ANTI && (|a_valid_i) && (m_starve >= SL);
            e_ch    = ((|c_valid_i) && !force_a) ? 1 : 0;
            for (int k = 1; k <= N; k++) begin
                if (!e_valid && ((e_ch == 1) ? c_valid_i[(m_ptr[e_ch] + k) % N]
                                             : a_valid_i[(m_ptr[e_ch] + k) % N])) begin
                    e_valid = 1'b1;
                    e_m     = (m_ptr[e_ch] + k) % N;
                end
            end
            e_first = 1'b1;
            e_beats = model_beats(e_ch, d_op[e_ch][e_m], d_sz[e_ch][e_m]);
            e_last  = (e_beats == 1);
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_ar, exp_cr;
        exp_ar = '0; exp_cr = '0;
        if (out_ready && (m_lock || e_valid)) begin
            if (e_ch == 1) exp_cr[e_m] = 1'b1;
            else           exp_ar[e_m] = 1'b1;
        end
        check_eq("out_valid", 128'(out_valid), 128'(e_valid));
        check_eq("busy", 128'(busy), 128'(m_lock));
        check_eq("a_ready", 128'(a_ready_o), 128'(exp_ar));
        check_eq("c_ready", 128'(c_ready_o), 128'(exp_cr));
        if (e_valid) begin
            check_eq("channel", 128'(out_channel), 128'(e_ch));
            check_eq("master", 128'(out_master_id), 128'(e_m));
            check_eq("opcode", 128'(out_opcode), 128'(d_op[e_ch][e_m]));
            check_eq("size", 128'(out_size), 128'(d_sz[e_ch][e_m]));
            check_eq("payload", 128'(out_payload), 128'(d_pay[e_ch][e_m]));
            check_eq("first", 128'(out_first), 128'(e_first));
            check_eq("last", 128'(out_last), 128'(e_last));
        end
    endtask

    task automatic model_commit(input bit acc);
        bit done;
        done = 1'b0;
        if (acc) begin
            if (m_lock) begin
                m_done++;
                if (m_done == m_total) begin
                    m_lock = 1'b0;
                    done   = 1'b1;
                end
            end else if (e_beats > 1) begin
                m_lock = 1'b1; m_lch = e_ch; m_lm = e_m; m_total = e_beats; m_done = 1;
            end else begin
                done = 1'b1;
            end
            if (done) begin
                m_ptr[e_ch] = e_m;
                d_has[e_ch][e_m] = 1'b0;
            end
        end
        if (!(|a_valid_i))  m_starve = 0;
        else if (done)      m_starve = (e_ch == 1) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
    endtask

    // One clock: compare at the falling edge, update at the rising edge,
    // drive new inputs just after it.
    task automatic step(input bit chk_m0);
        bit acc;
        @(negedge clk);
        model_eval();
        compare();
        if (chk_m0) check_eq("first_grant_m0", 128'(out_master_id), 128'(0));
        if (mode == 1 && out_valid && out_ready) begin
            if (out_channel == 1'b0) begin
                if (obs_a_at < 0) obs_a_at = obs_c_done;
            end else if (out_last) begin
                obs_c_done++;
            end
        end
        acc = e_valid && out_ready;
        @(posedge clk);
        model_commit(acc);
        #1;
        new_stimulus();
    endtask

    // Entered and left just after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_a_ready", 128'(a_ready_o), 128'(0));
        check_eq("rst_c_ready", 128'(c_ready_o), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        clear_masters();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 2;
        out_ready = 1'b1;
        clear_masters();
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Two A Gets back to back: M0 then M1
        set_msg(0, 0, 4, 6); set_msg(0, 1, 4, 6); pack();
        step(1'b1); step(1'b0); step(1'b0);

        // Downstream stall with both A requesters pending
        set_msg(0, 0, 4, 6); set_msg(0, 1, 4, 6); out_ready = 1'b0; pack();
        repeat (5) step(1'b0);
        out_ready = 1'b1;
        repeat (3) step(1'b0);

        // A Get against an 8-beat C ReleaseData
        set_msg(0, 0, 4, 6); set_msg(1, 1, 7, 6); pack();
        repeat (12) step(1'b0);

        // Randomized traffic with valid drops and back-pressure
        mode = 0;
        new_stimulus();
        repeat (3000) step(1'b0);

        // Drain in-flight messages
        mode = 2; out_ready = 1'b1;
        for (int ch = 0; ch < 2; ch++) for (int m = 0; m < N; m++) d_drop[ch][m] = 1'b0;
        pack();
        repeat (40) step(1'b0);

        // Reset in the middle of an 8-beat PutFullData
        clear_masters();
        set_msg(0, 1, 0, 6); pack();
        repeat (3) step(1'b0);
        check_eq("busy_mid_burst", 128'(busy), 128'(1));
        apply_reset();
        set_msg(0, 0, 4, 6); set_msg(0, 1, 4, 6); pack();
        step(1'b1); step(1'b0);

        // Continuous C Release traffic with an A Get pending
        mode = 1;
        apply_reset();
        new_stimulus();
        repeat (40) step(1'b0);
        check_eq("starve_a_after_c", 128'(obs_a_at), 128'(ANTI ? SL : -1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
